inv_key_scheduler: RTL and testbench
====================================

INV_KEY_SCHEDULER -- requirements
Module: inv_key_scheduler

Interface
REQ-001 SHALL have parameter BLOCK_LENGTH, default 128, round-key width; only 128 (AES-128) is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port load  input  1  pulse that captures `key` and starts a schedule.
REQ-005 SHALL have port key  input  128  cipher key K0, sampled only when load=1.
REQ-006 SHALL have port next  input  1  request for the next round key in descending order.
REQ-007 SHALL have port round_key  output  128  current round key, registered.
REQ-008 SHALL have port round_idx  output  4  index (10..0) of round_key.
REQ-009 SHALL have port key_valid  output  1  one-cycle pulse: round_key/round_idx updated.
REQ-010 SHALL have port busy  output  1  high while state is EXPAND.
REQ-011 SHALL have port ready  output  1  high while state is SERVE.
REQ-012 SHALL have port done  output  1  one-cycle pulse, coincident with key_valid for K0.

Function
REQ-013 SHALL implement FSM states IDLE, EXPAND, SERVE; encoding free.
REQ-014 SHALL hold only one 128-bit working key register plus round_key; no 11-key storage.
REQ-015 SHALL give load highest priority in every state: on the edge sampling load=1, work_key<=key, counter<=1, state<=EXPAND; any schedule in progress is aborted without key_valid.
REQ-016 In EXPAND, each edge SHALL apply forward expansion: w4=w0^g(w3,rcon(c)), w5=w1^w4, w6=w2^w5, w7=w3^w6; then c<=c+1.
REQ-017 SHALL use rcon(1..10) = 01,02,04,08,10,20,40,80,1B,36; any other index yields 00.
REQ-018 On the EXPAND edge with c=10, SHALL write K10 to work_key and round_key, set round_idx=10, pulse key_valid, and enter SERVE.
REQ-019 key_valid for K10 SHALL be high in the 10th cycle after the cycle in which load was sampled.
REQ-020 In SERVE with next=1 and round_idx=i>0, SHALL apply inverse expansion on one edge: w3'=w7^w6, w2'=w6^w5, w1'=w5^w4, w0'=w4^g(w3',rcon(i)). The result goes to work_key and round_key, round_idx<=i-1, and key_valid pulses.
REQ-021 SHALL accept next on consecutive cycles, giving one key per cycle, with 1-cycle latency from next to key_valid.
REQ-022 When the inverse step produces K0 (i=1), SHALL pulse done with key_valid and enter IDLE; round_key/round_idx hold K0/0.
REQ-023 SHALL ignore next in IDLE and EXPAND; next in SERVE with no load SHALL NOT be lost or double-counted.
REQ-024 SHALL use one combinational g_function (RotWord, SubWord, XOR rcon into MSB byte) with a muxed input: w3 in EXPAND, w3' in SERVE.
REQ-025 round_key and round_idx SHALL hold their value when key_valid=0.
REQ-026 key_valid and done SHALL never be high for more than one consecutive cycle per key.

Reset
REQ-027 When rst=0, SHALL immediately set state=IDLE and clear work_key, counter, round_key, round_idx, key_valid, busy, ready, done to 0, independent of clk.
REQ-028 After rst deasserts, SHALL take no action until load=1.

Verification
REQ-029 Assert rst=0 mid-EXPAND (5th cycle) -> all outputs 0 at once; state IDLE; next ignored afterwards.
REQ-030 load with key=2b7e151628aed2a6abf7158809cf4f3c -> busy for 10 cycles. Then key_valid, round_idx=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6, ready=1.
REQ-031 Then 10 back-to-back next pulses -> first response round_idx=9, round_key=ac7766f319fadc2128d12941575c006e. Response at idx 1 is a0fafe1788542cb123a339392a6c7605. Last response is idx 0, 2b7e1516...4f3c with done=1, then IDLE.
REQ-032 next pulses during EXPAND and in IDLE -> no key_valid, round_key unchanged, K10 timing unaffected.
REQ-033 In SERVE at round_idx=6, assert load with the same key -> no key_valid in that cycle. K10 appears 10 cycles later and the descending sequence is correct.
REQ-034 SERVE with next held low for 20 cycles, then next once -> exactly one key_valid, and round_idx decrements by one.

Source files
------------

// File: rtl/inv_key_scheduler.sv
// inv_key_scheduler: AES-128 key schedule that expands K0 to K10, then serves round keys K10..K0 on request
//   clk        : single clock, rising edge
//   rst        : asynchronous active-low reset
//   load/key   : capture cipher key K0 and start a new schedule (wins in every state)
//   next       : request the next round key in descending order (SERVE only)
//   round_key  : current round key (registered), index in round_idx
//   key_valid  : one-cycle pulse when round_key/round_idx update
//   busy/ready : state is EXPAND / SERVE
//   done       : one-cycle pulse together with key_valid for K0
module inv_key_scheduler #(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [BLOCK_LENGTH-1:0] key,
  input  logic                    next,
  output logic [BLOCK_LENGTH-1:0] round_key,
  output logic [3:0]              round_idx,
  output logic                    key_valid,
  output logic                    busy,
  output logic                    ready,
  output logic                    done
);
  typedef enum logic [1:0] {IDLE, EXPAND, SERVE} state_t;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  // Entry x sits at the (255-x)th byte from the bottom; 255-x is simply ~x.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [31:0] g_function(input logic [31:0] w, input logic [7:0] rc);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]) ^ rc, sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction
  state_t                  state_q, state_d;
  logic [BLOCK_LENGTH-1:0] work_q, work_d, rk_q, rk_d;
  logic [3:0]              cnt_q, cnt_d, idx_q, idx_d;
  logic                    kv_q, kv_d, done_q, done_d;
  logic [31:0]             w0, w1, w2, w3, i1, i2, i3, gw;
  logic [BLOCK_LENGTH-1:0] fwd, inv;
  assign {w0, w1, w2, w3} = work_q;
  // Inverse step: the three low words of the previous key fall out of XORs of the current one.
  assign i3 = w3 ^ w2;
  assign i2 = w2 ^ w1;
  assign i1 = w1 ^ w0;
  // One shared g: forward uses w3 with rcon(counter), inverse uses w3' with rcon(round_idx).
  assign gw = state_q == SERVE ? g_function(i3, rcon(idx_q)) : g_function(w3, rcon(cnt_q));
  assign fwd[127:96] = w0 ^ gw;
  assign fwd[95:64]  = w1 ^ fwd[127:96];
  assign fwd[63:32]  = w2 ^ fwd[95:64];
  assign fwd[31:0]   = w3 ^ fwd[63:32];
  assign inv = {w0 ^ gw, i1, i2, i3};
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    kv_d    = 1'b0;
    done_d  = 1'b0;
    if (load) begin
      work_d  = key;
      cnt_d   = 4'd1;
      state_d = EXPAND;
    end else if (state_q == EXPAND) begin
      work_d = fwd;
      cnt_d  = cnt_q + 4'd1;
      if (cnt_q == 4'd10) begin
        rk_d    = fwd;
        idx_d   = 4'd10;
        kv_d    = 1'b1;
        state_d = SERVE;
      end
    end else if (state_q == SERVE && next && idx_q != 4'd0) begin
      work_d  = inv;
      rk_d    = inv;
      idx_d   = idx_q - 4'd1;
      kv_d    = 1'b1;
      done_d  = idx_q == 4'd1;
      state_d = idx_q == 4'd1 ? IDLE : SERVE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      rk_q    <= '0;
      idx_q   <= '0;
      kv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      kv_q    <= kv_d;
      done_q  <= done_d;
    end
  end
  assign round_key = rk_q;
  assign round_idx = idx_q;
  assign key_valid = kv_q;
  assign done      = done_q;
  assign busy      = state_q == EXPAND;
  assign ready     = state_q == SERVE;
endmodule

// File: tb/tb_inv_key_scheduler.sv
// tb_inv_key_scheduler: directed checks of the inverse key scheduler against the FIPS-197 AES-128 example schedule
module tb_inv_key_scheduler;
  logic         clk, rst, load, next;
  logic [127:0] key, round_key;
  logic [3:0]   round_idx;
  logic         key_valid, busy, ready, done;
  logic [127:0] k [0:10];
  int           n_cmp = 0;
  int           n_err = 0;

  inv_key_scheduler #(.BLOCK_LENGTH(128)) dut (
    .clk(clk), .rst(rst), .load(load), .key(key), .next(next),
    .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
    .busy(busy), .ready(ready), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s mismatch", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rk"}, round_key, 128'h0);
    chk({tag, "_idx"}, 128'(round_idx), 128'h0);
    chk({tag, "_flags"}, 128'({key_valid, busy, ready, done}), 128'h0);
  endtask

  initial begin
    k[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    k[9]  = 128'hac7766f319fadc2128d12941575c006e;
    k[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rst = 1'b1; load = 1'b0; next = 1'b0; key = '0;
    #2 rst = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    rst = 1'b1;
    // Idle: next must be ignored.
    next = 1'b1;
    step();
    step();
    next = 1'b0;
    chk_all_zero("idle_next");
    // Asynchronous reset in the middle of an expansion.
    key = k[0]; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_expand_busy", 128'(busy), 128'h1);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    step();
    rst = 1'b1;
    next = 1'b1;
    for (int i = 0; i < 12; i++) step();
    next = 1'b0;
    chk_all_zero("post_rst_next");
    // Full expansion with next toggling during EXPAND.
    key = k[0]; load = 1'b1;
    step();
    load = 1'b0; next = 1'b1;
    chk("exp_busy0", 128'({busy, key_valid}), 128'h2);
    for (int i = 1; i < 10; i++) begin
      if (i == 9) next = 1'b0;
      step();
      chk($sformatf("exp_busy%0d", i), 128'({busy, key_valid, ready}), 128'h4);
      chk($sformatf("exp_rk%0d", i), round_key, 128'h0);
    end
    step();
    chk("k10_flags", 128'({key_valid, busy, ready, done}), 128'ha);
    chk("k10_idx", 128'(round_idx), 128'd10);
    chk("k10_rk", round_key, k[10]);
    // Back-to-back descending keys.
    next = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      step();
      chk($sformatf("desc_kv%0d", i), 128'({key_valid, done}), 128'({1'b1, i == 0}));
      chk($sformatf("desc_idx%0d", i), 128'(round_idx), 128'(i));
      chk($sformatf("desc_rk%0d", i), round_key, k[i]);
    end
    step();
    chk("after_k0_flags", 128'({key_valid, busy, ready, done}), 128'h0);
    chk("after_k0_rk", round_key, k[0]);
    chk("after_k0_idx", 128'(round_idx), 128'h0);
    step();
    next = 1'b0;
    chk("idle_hold_rk", round_key, k[0]);
    chk("idle_hold_kv", 128'(key_valid), 128'h0);
    // Reload while serving at round_idx 6.
    key = k[0]; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("re_k10_rk", round_key, k[10]);
    next = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("at6_idx", 128'(round_idx), 128'd6);
    chk("at6_rk", round_key, k[6]);
    load = 1'b1;
    step();
    load = 1'b0; next = 1'b0;
    chk("abort_flags", 128'({key_valid, busy, ready}), 128'h2);
    chk("abort_rk", round_key, k[6]);
    for (int i = 0; i < 9; i++) step();
    chk("abort_pre_kv", 128'(key_valid), 128'h0);
    step();
    chk("abort_k10_kv", 128'({key_valid, ready}), 128'h3);
    chk("abort_k10_rk", round_key, k[10]);
    next = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      step();
      chk($sformatf("abort_desc_rk%0d", i), round_key, k[i]);
    end
    next = 1'b0;
    chk("abort_done", 128'(done), 128'h1);
    // Long idle in SERVE, then a single next.
    key = k[0]; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 10; i++) step();
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("hold_kv%0d", i), 128'({key_valid, round_idx}), 128'(5'd10));
    end
    next = 1'b1;
    step();
    next = 1'b0;
    chk("single_kv", 128'({key_valid, round_idx}), 128'({1'b1, 4'd9}));
    chk("single_rk", round_key, k[9]);
    step();
    chk("single_after", 128'({key_valid, round_idx, ready}), 128'({1'b0, 4'd9, 1'b1}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
